// File: rtl/fp_div_pkg.sv
// Shared types and width/constant helpers for the floating-point divider arbiter.
package fp_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    function automatic int word_bits(input int exp_bits, input int mant_bits);
        return exp_bits + mant_bits + 1;
    endfunction

    function automatic int id_bits(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set; caller truncates to WORD.
    function automatic logic [127:0] qnan_bits(input int exp_bits, input int mant_bits);
        logic [127:0] v;
        v = ((128'd1 << exp_bits) - 128'd1) << mant_bits;
        v = v | (128'd1 << (mant_bits - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_div_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_any && i_req[w_cand[IW-1:0]]) begin
                o_any                 = 1'b1;
                o_idx                 = w_cand[IW-1:0];
                o_gnt[w_cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one variable-latency FP divider, with hang watchdog/flush.
module fp_div_arbiter
    import fp_div_pkg::*;
#(
    parameter int MANT_BITS   = 23,
    parameter int EXP_BITS    = 8,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 256,
    localparam int WORD       = word_bits(EXP_BITS, MANT_BITS),
    localparam int IDW        = id_bits(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*WORD-1:0] req_a,
    input  logic [NUM_REQ*WORD-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WORD-1:0]         rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    div_input_valid,
    output logic [WORD-1:0]         div_a,
    output logic [WORD-1:0]         div_b,
    output logic                    div_rst_n,
    input  logic [WORD-1:0]         div_data_out,
    input  logic                    div_output_valid
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WORD-1:0] QNAN = WORD'(qnan_bits(EXP_BITS, MANT_BITS));

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_cur_id;
    logic [IDW-1:0]   r_rsp_id;
    logic [WORD-1:0]  r_op_a;
    logic [WORD-1:0]  r_op_b;
    logic [WORD-1:0]  r_rsp_data;
    logic             r_rsp_err;
    logic [TW-1:0]    r_timer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_any;
    logic             w_timeout;

    rr_grant #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_grant (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    assign w_timeout = (r_timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Result arriving on the timeout cycle wins over the flush.
    always_comb begin
        w_next          = r_state;
        req_ready       = '0;
        rsp_valid       = 1'b0;
        div_input_valid = 1'b0;
        div_rst_n       = ~reset;
        busy            = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req_ready = reset ? '0 : w_gnt;
                if (w_any) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                div_input_valid = 1'b1;
                w_next          = S_BUSY;
            end
            S_BUSY: begin
                if (div_output_valid) w_next = S_RESP;
                else if (w_timeout)   w_next = S_FLUSH;
            end
            S_FLUSH: begin
                div_rst_n = 1'b0;
                w_next    = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_cur_id   <= '0;
            r_rsp_id   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= req_a[int'(w_gnt_idx)*WORD +: WORD];
                        r_op_b   <= req_b[int'(w_gnt_idx)*WORD +: WORD];
                        r_cur_id <= w_gnt_idx;
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_BUSY: begin
                    r_timer <= r_timer + TW'(1);
                    if (div_output_valid) begin
                        r_rsp_data <= div_data_out;
                        r_rsp_err  <= 1'b0;
                        r_rsp_id   <= r_cur_id;
                    end
                end
                S_FLUSH: begin
                    r_rsp_data <= QNAN;
                    r_rsp_err  <= 1'b1;
                    r_rsp_id   <= r_cur_id;
                end
                S_RESP: begin
                    r_rr_ptr <= (r_cur_id == IDW'(NUM_REQ - 1)) ? '0 : r_cur_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign div_a    = r_op_a;
    assign div_b    = r_op_b;
    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter: behavioural divider stub, expected-response queue, summary.
module tb_fp_div_arbiter;

    localparam int MB  = 23;
    localparam int EB  = 8;
    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int EW  = IDW + 1 + W;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              div_input_valid;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic              div_rst_n;
    logic [W-1:0]      div_data_out;
    logic              div_output_valid;

    fp_div_arbiter #(
        .MANT_BITS   (MB),
        .EXP_BITS    (EB),
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .div_input_valid  (div_input_valid),
        .div_a            (div_a),
        .div_b            (div_b),
        .div_rst_n        (div_rst_n),
        .div_data_out     (div_data_out),
        .div_output_valid (div_output_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [EW-1:0] exp_q[$];
    int served_q[$];
    int stub_cnt = 0;
    int stub_lat = 1;
    bit stub_never = 1'b0;
    bit stub_spur  = 1'b0;
    int t_now = 0;
    int t_rsp = 0;
    int t0    = 0;
    int n_rsp, n_issue, n_dflush, n_busy;
    int n_ready[NR];
    logic [W-1:0] iss_a, iss_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Hand-computed IEEE-754 single quotients for the operand pairs used below.
    function automatic logic [W-1:0] quot(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        if (a == 32'h41200000 && b == 32'h40A00000) return 32'h40000000;
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [EW-1:0] mk(input int id, input logic err, input logic [W-1:0] d);
        return {IDW'(id), err, d};
    endfunction

    function automatic int served_at(input int k);
        return (served_q.size() > k) ? served_q[k] : -1;
    endfunction

    task automatic clear_counts();
        n_rsp = 0; n_issue = 0; n_dflush = 0; n_busy = 0;
        for (int i = 0; i < NR; i++) n_ready[i] = 0;
        served_q.delete();
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
    endtask

    // One clock: sample at negedge, drive divider stub, drop served requests after posedge.
    task automatic tick();
        logic [NR-1:0] rdy;
        logic [EW-1:0] e;
        @(negedge clk);
        t_now++;
        if (rsp_valid) begin
            n_rsp++;
            t_rsp = t_now;
            if (exp_q.size() == 0) begin
                chk("unexp_rsp", {rsp_id, rsp_err, rsp_data}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {rsp_id, rsp_err, rsp_data}, e);
            end
        end
        if (div_input_valid) begin
            n_issue++;
            iss_a = div_a;
            iss_b = div_b;
        end
        if (!reset && !div_rst_n) n_dflush++;
        if (busy && !div_input_valid && !rsp_valid && div_rst_n) n_busy++;
        rdy = req_ready;
        for (int i = 0; i < NR; i++) begin
            if (rdy[i]) begin
                n_ready[i]++;
                served_q.push_back(i);
            end
        end
        div_output_valid = 1'b0;
        if (reset) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    div_output_valid = 1'b1;
                    div_data_out     = quot(div_a, div_b);
                end
            end
            if (div_input_valid && !stub_never) stub_cnt = stub_lat;
            if (stub_spur) begin
                div_output_valid = 1'b1;
                div_data_out     = 32'h12345678;
                stub_spur        = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (rdy[i]) req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (exp_q.size() == 0 && req_valid == '0 && !busy) break;
        end
        chk("pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_divrst", div_rst_n, 0);
        reset = 1'b0;
        #1;
        chk("rel_divrst", div_rst_n, 1);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        div_output_valid = 1'b0; div_data_out = '0;
        clear_counts();

        // Reset values
        repeat (3) tick();
        req_valid = 4'hF;
        #1;
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        chk("rst_busy", busy, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rsp", {rsp_id, rsp_err, rsp_data}, 0);
        chk("rst_divin", div_input_valid, 0);
        chk("rst_diva", {div_a, div_b}, 0);
        chk("rst_divrst", div_rst_n, 0);
        reset = 1'b0;
        #1;
        chk("rel_divrst", div_rst_n, 1);

        // Single request from id 2, divider latency 3
        clear_counts();
        stub_lat = 3;
        set_req(2, 32'h40C00000, 32'h40000000);
        exp_q.push_back(mk(2, 1'b0, 32'h40400000));
        t0 = t_now;
        wait_done(50);
        chk("t1_nrsp", n_rsp, 1);
        chk("t1_ready2", n_ready[2], 1);
        chk("t1_ready_oth", n_ready[0] + n_ready[1] + n_ready[3], 0);
        chk("t1_issue", n_issue, 1);
        chk("t1_ops", {iss_a, iss_b}, {32'h40C00000, 32'h40000000});
        chk("t1_flush", n_dflush, 0);
        chk("t1_lat", t_rsp - t0, 6);
        chk("t1_busycyc", n_busy, 3);
        chk("t1_hold", {rsp_valid, rsp_data}, {1'b0, 32'h40400000});

        // All four requesters after reset: order 0,1,2,3, then pointer wrap cases
        do_reset();
        clear_counts();
        stub_lat = 2;
        for (int k = 0; k < NR; k++) begin
            set_req(k, 32'h3F800000, 32'h40800000);
            exp_q.push_back(mk(k, 1'b0, 32'h3E800000));
        end
        wait_done(100);
        chk("t2_nrsp", n_rsp, 4);
        chk("t2_issue", n_issue, 4);
        for (int k = 0; k < NR; k++) chk("t2_order", served_at(k), k);

        clear_counts();
        set_req(0, 32'h40C00000, 32'h40000000);
        set_req(2, 32'h41200000, 32'h40A00000);
        exp_q.push_back(mk(0, 1'b0, 32'h40400000));
        exp_q.push_back(mk(2, 1'b0, 32'h40000000));
        wait_done(100);
        chk("t2b_first", served_at(0), 0);
        chk("t2b_second", served_at(1), 2);

        clear_counts();
        set_req(1, 32'h40C00000, 32'h40000000);
        set_req(3, 32'h3F800000, 32'h40800000);
        exp_q.push_back(mk(3, 1'b0, 32'h3E800000));
        exp_q.push_back(mk(1, 1'b0, 32'h40400000));
        wait_done(100);
        chk("t2c_first", served_at(0), 3);
        chk("t2c_second", served_at(1), 1);

        // Divider never answers: watchdog flush returns quiet NaN with error
        clear_counts();
        stub_never = 1'b1;
        set_req(1, 32'h3F800000, 32'h40800000);
        exp_q.push_back(mk(1, 1'b1, 32'h7FC00000));
        wait_done(100);
        chk("t3_flush", n_dflush, 1);
        chk("t3_busycyc", n_busy, TO);
        chk("t3_nrsp", n_rsp, 1);
        stub_never = 1'b0;
        clear_counts();
        stub_lat = 1;
        set_req(0, 32'h40C00000, 32'h40000000);
        exp_q.push_back(mk(0, 1'b0, 32'h40400000));
        wait_done(50);
        chk("t3b_flush", n_dflush, 0);
        chk("t3b_nrsp", n_rsp, 1);

        // Spurious divider pulse while idle; pointer must still be 1
        clear_counts();
        stub_spur = 1'b1;
        repeat (4) begin
            tick();
            chk("t6_busy", busy, 0);
        end
        chk("t6_nrsp", n_rsp, 0);
        chk("t6_issue", n_issue, 0);
        set_req(0, 32'h40C00000, 32'h40000000);
        set_req(2, 32'h41200000, 32'h40A00000);
        exp_q.push_back(mk(2, 1'b0, 32'h40000000));
        exp_q.push_back(mk(0, 1'b0, 32'h40400000));
        wait_done(100);
        chk("t6_first", served_at(0), 2);

        // Answer on exactly the last allowed BUSY cycle
        clear_counts();
        stub_lat = TO;
        set_req(3, 32'h3F800000, 32'h40800000);
        exp_q.push_back(mk(3, 1'b0, 32'h3E800000));
        wait_done(100);
        chk("t4_flush", n_dflush, 0);
        chk("t4_busycyc", n_busy, TO);
        chk("t4_nrsp", n_rsp, 1);

        // Reset during BUSY drops the operation
        clear_counts();
        stub_never = 1'b1;
        set_req(2, 32'h3F800000, 32'h40800000);
        repeat (5) tick();
        chk("t5_inbusy", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_divrst", div_rst_n, 0);
        chk("t5_rspv", rsp_valid, 0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("t5_rel", div_rst_n, 1);
        stub_never = 1'b0;
        stub_lat = 2;
        clear_counts();
        set_req(3, 32'h40C00000, 32'h40000000);
        exp_q.push_back(mk(3, 1'b0, 32'h40400000));
        wait_done(50);
        chk("t5_grant3", served_at(0), 3);
        chk("t5_nrsp", n_rsp, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
